// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an SPI controller (master) and the register peripheral (slave).
interface spi_peripheral_if;
    logic sclk_in;
    logic copi_in;
    logic ncs_in;

    modport master (output sclk_in, output copi_in, output ncs_in);
    modport slave  (input  sclk_in, input  copi_in, input  ncs_in);
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register block: oversamples the SPI pins on clk and
// commits 16-bit {R/W, addr[6:0], data[7:0]} frames into five control registers.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_peripheral_if.slave  spi,
    output logic [7:0]       en_reg_out_7_0,
    output logic [7:0]       en_reg_out_15_8,
    output logic [7:0]       en_reg_pwm_7_0,
    output logic [7:0]       en_reg_pwm_15_8,
    output logic [7:0]       pwm_duty_cycle,
    output logic             reg_wr_stb,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic                   r_sclk_d, r_ncs_d;
    logic [15:0]            r_shift;
    logic [4:0]             r_count;
    logic [7:0]             r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;
    logic                   r_wr_stb;
    state_t                 r_state, r_state_next;

    logic w_sclk, w_copi, w_ncs;
    logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
    logic w_clear, w_shift_en, w_commit, w_wr_ok;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs & r_ncs_d;
    assign w_ncs_rise  = w_ncs & ~r_ncs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk_in};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi_in};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.ncs_in};
            r_sclk_d    <= w_sclk;
            r_ncs_d     <= w_ncs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= r_state_next;
    end

    // A chip-select fall seen during COMMIT starts the next frame directly.
    always_comb begin
        r_state_next = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    r_state_next = ST_SHIFT;
                    w_clear      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise)       r_state_next = ST_COMMIT;
                else if (w_sclk_rise) w_shift_en   = 1'b1;
            end
            ST_COMMIT: begin
                w_commit = 1'b1;
                if (w_ncs_fall) begin
                    r_state_next = ST_SHIFT;
                    w_clear      = 1'b1;
                end else begin
                    r_state_next = ST_IDLE;
                end
            end
            default: r_state_next = ST_IDLE;
        endcase
    end

    assign w_wr_ok = w_commit && (r_count == 5'd16) && r_shift[15] && (r_shift[14:8] <= MAX_A);

    // Count saturates at 17 so any frame longer than 16 bits stays flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_shift_en && (r_count != 5'd17)) begin
            r_count <= r_count + 5'd1;
            if (r_count != 5'd16) r_shift <= {r_shift[14:0], w_copi};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg0   <= '0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_reg3   <= '0;
            r_reg4   <= '0;
            r_wr_stb <= 1'b0;
        end else begin
            r_wr_stb <= w_wr_ok;
            if (w_wr_ok) begin
                case (r_shift[14:8])
                    7'd0:    r_reg0 <= r_shift[7:0];
                    7'd1:    r_reg1 <= r_shift[7:0];
                    7'd2:    r_reg2 <= r_shift[7:0];
                    7'd3:    r_reg3 <= r_shift[7:0];
                    7'd4:    r_reg4 <= r_shift[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_reg0;
    assign en_reg_out_15_8 = r_reg1;
    assign en_reg_pwm_7_0  = r_reg2;
    assign en_reg_pwm_15_8 = r_reg3;
    assign pwm_duty_cycle  = r_reg4;
    assign reg_wr_stb      = r_wr_stb;
    assign dbg_state       = r_state;

endmodule
